// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for a multicycle processor. Two request ports share
//   one single-ported 2**ADDR_W x DATA_W array:
//     - the instruction-fetch port, which can only read
//     - the data port, which can read or write
//   The block arbitrates between the ports and inserts WAIT_STATES wait cycles.
//   It completes each access with a one-cycle ack pulse. Address IO_ADDR is
//   decoded to the io_out register instead of the array.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-high reset
//   i_req/i_addr     fetch request and address
//   i_ack/i_rdata    fetch completion pulse and data (held until next fetch ack)
//   d_req/d_we       data request, 1 = write
//   d_addr/d_wdata   data address and write data
//   d_ack/d_rdata    data completion pulse and read data (held until next read ack)
//   io_out           memory-mapped output register
//   busy             high whenever the FSM is not IDLE
//
// Handshake (both ports)
//   The requester raises req with stable address, we and wdata. It holds them
//   until it samples ack=1, and drops req on that same edge. The responder
//   latches the request when it grants it, so later input changes do nothing.
//   A req that falls before it is granted is ignored. At most one ack is high
//   in any cycle.
module mem_responder #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] IO_ADDR     = 8'hFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [DATA_W-1:0] io_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              last_grant;      // 0 = instruction, 1 = data

    // Latched copy of the granted request.
    logic              g_data;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    logic              grant;
    logic              grant_data;
    logic              access;          // this edge enters RESP and performs the access
    logic              a_data;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_is_io;
    logic [DATA_W-1:0] rd_val;
    logic              mem_we;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        grant      = 1'b0;
        grant_data = 1'b0;
        access     = 1'b0;
        a_data     = g_data;
        a_we       = g_we;
        a_addr     = g_addr;
        a_wdata    = g_wdata;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant      = 1'b1;
                    // On a tie the port that did not win last time is granted.
                    grant_data = d_req && (!i_req || !last_grant);
                    if (WAIT_STATES == 0) begin
                        // With no wait states the access happens on the grant
                        // edge itself, so it must use the live port inputs.
                        state_nx = RESP;
                        access   = 1'b1;
                        a_data   = grant_data;
                        a_we     = grant_data && d_we;
                        a_addr   = grant_data ? d_addr : i_addr;
                        a_wdata  = d_wdata;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                    access   = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign a_is_io = (a_addr == IO_ADDR);
    assign rd_val  = a_is_io ? io_out : mem[a_addr];
    assign busy    = (state != IDLE);
    // An asserted reset also blocks a commit. Without this, a WAIT_STATES==0
    // grant could still write while reset is held.
    assign mem_we  = access && a_we && !a_is_io && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b0;
            g_data     <= 1'b0;
            g_we       <= 1'b0;
            g_addr     <= '0;
            g_wdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            io_out     <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            if (grant) begin
                last_grant <= grant_data;
                g_data     <= grant_data;
                g_we       <= grant_data && d_we;
                g_addr     <= grant_data ? d_addr : i_addr;
                g_wdata    <= d_wdata;
            end
            if (access) begin
                if (a_data) d_ack <= 1'b1;
                else        i_ack <= 1'b1;
                if (a_we) begin
                    if (a_is_io) io_out <= a_wdata;
                end else if (a_data) begin
                    d_rdata <= rd_val;
                end else begin
                    i_rdata <= rd_val;
                end
            end
        end
    end

    // The array has no reset; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) mem[a_addr] <= a_wdata;
    end

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
module tb_mem_responder;
    localparam int NI = 2;  // instance 0: WAIT_STATES=1, instance 1: WAIT_STATES=0

    logic       clock = 1'b0;
    logic       reset;
    logic       i_req   [NI];
    logic [7:0] i_addr  [NI];
    logic       i_ack   [NI];
    logic [7:0] i_rdata [NI];
    logic       d_req   [NI];
    logic       d_we    [NI];
    logic [7:0] d_addr  [NI];
    logic [7:0] d_wdata [NI];
    logic       d_ack   [NI];
    logic [7:0] d_rdata [NI];
    logic [7:0] io_out  [NI];
    logic       busy    [NI];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_responder #(
            .ADDR_W(8), .DATA_W(8), .WAIT_STATES((g == 0) ? 1 : 0), .IO_ADDR(8'hFF)
        ) u_dut (
            .clock(clock), .reset(reset),
            .i_req(i_req[g]), .i_addr(i_addr[g]), .i_ack(i_ack[g]), .i_rdata(i_rdata[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_ack(d_ack[g]), .d_rdata(d_rdata[g]), .io_out(io_out[g]), .busy(busy[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    // ---------------- behavioural model ----------------
    // Transaction-level: a request accepted at edge n acks at edge n+ws. The
    // instance is free again from edge n+ws+2 on.
    logic [7:0] m_mem  [NI][256];
    bit         m_act  [NI] = '{0, 0};
    int         m_acc  [NI] = '{0, 0};
    bit         m_last [NI] = '{0, 0};   // 1 = data won last
    bit         m_gd   [NI];
    bit         m_gwe  [NI];
    logic [7:0] m_ga   [NI];
    logic [7:0] m_gw   [NI];
    logic       m_iack [NI] = '{0, 0};
    logic       m_dack [NI] = '{0, 0};
    logic [7:0] m_ird  [NI] = '{0, 0};
    logic [7:0] m_drd  [NI] = '{0, 0};
    logic [7:0] m_io   [NI] = '{0, 0};
    logic       m_busy [NI] = '{0, 0};
    bit         m_done;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NI; k++) begin
                m_act[k] = 0; m_last[k] = 0; m_iack[k] = 0; m_dack[k] = 0;
                m_ird[k] = 0; m_drd[k] = 0; m_io[k] = 0; m_busy[k] = 0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < NI; k++) begin
                m_iack[k] = 0;
                m_dack[k] = 0;
                m_done    = 0;
                if (m_act[k] && cyc == m_acc[k] + ws_of(k) + 1) begin
                    m_act[k] = 0; m_busy[k] = 0; m_done = 1;
                end
                if (!m_act[k] && !m_done && (i_req[k] || d_req[k])) begin
                    m_gd[k]   = (i_req[k] && d_req[k]) ? !m_last[k] : d_req[k];
                    m_last[k] = m_gd[k];
                    m_gwe[k]  = m_gd[k] && d_we[k];
                    m_ga[k]   = m_gd[k] ? d_addr[k] : i_addr[k];
                    m_gw[k]   = d_wdata[k];
                    m_act[k]  = 1; m_acc[k] = cyc; m_busy[k] = 1;
                end
                if (m_act[k] && cyc == m_acc[k] + ws_of(k)) begin
                    if (m_gd[k]) m_dack[k] = 1; else m_iack[k] = 1;
                    if (m_gwe[k]) begin
                        if (m_ga[k] == 8'hFF) m_io[k] = m_gw[k];
                        else                  m_mem[k][m_ga[k]] = m_gw[k];
                    end else if (m_gd[k]) begin
                        m_drd[k] = (m_ga[k] == 8'hFF) ? m_io[k] : m_mem[k][m_ga[k]];
                    end else begin
                        m_ird[k] = (m_ga[k] == 8'hFF) ? m_io[k] : m_mem[k][m_ga[k]];
                    end
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h (cyc %0d)", name, k, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            for (int k = 0; k < NI; k++) begin
                chk("i_ack",   k, 32'(i_ack[k]),   32'(m_iack[k]));
                chk("d_ack",   k, 32'(d_ack[k]),   32'(m_dack[k]));
                chk("i_rdata", k, 32'(i_rdata[k]), 32'(m_ird[k]));
                chk("d_rdata", k, 32'(d_rdata[k]), 32'(m_drd[k]));
                chk("io_out",  k, 32'(io_out[k]),  32'(m_io[k]));
                chk("busy",    k, 32'(busy[k]),    32'(m_busy[k]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_data(input int k, input bit we, input logic [7:0] a, input logic [7:0] wd,
                           output int ack_cyc, output int lat, output logic [7:0] rd);
        int n = 0;
        @(posedge clock); #1;
        d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd;
        ack_cyc = -1; rd = '0;
        while (ack_cyc < 0 && n < 40) begin
            @(negedge clock); n++;
            if (d_ack[k] === 1'b1) begin ack_cyc = cyc; rd = d_rdata[k]; end
        end
        lat = n;
        if (ack_cyc < 0) begin
            total++; bad++;
            $display("FAIL d_timeout[%0d]: got no d_ack want d_ack within 40 cycles", k);
        end
        @(posedge clock); #1;
        d_req[k] = 1'b0;
    endtask

    task automatic do_fetch(input int k, input logic [7:0] a, output int ack_cyc, output logic [7:0] rd);
        int n = 0;
        @(posedge clock); #1;
        i_req[k] = 1'b1; i_addr[k] = a;
        ack_cyc = -1; rd = '0;
        while (ack_cyc < 0 && n < 40) begin
            @(negedge clock); n++;
            if (i_ack[k] === 1'b1) begin ack_cyc = cyc; rd = i_rdata[k]; end
        end
        if (ack_cyc < 0) begin
            total++; bad++;
            $display("FAIL i_timeout[%0d]: got no i_ack want i_ack within 40 cycles", k);
        end
        @(posedge clock); #1;
        i_req[k] = 1'b0;
    endtask

    task automatic wr(input int k, input logic [7:0] a, input logic [7:0] wd);
        int ac, lt; logic [7:0] rd;
        do_data(k, 1'b1, a, wd, ac, lt, rd);
    endtask

    task automatic prefill(input int k);
        for (int a = 0; a < 255; a++) wr(k, 8'(a), 8'($urandom_range(0, 255)));
    endtask

    task automatic rnd_fetch(input int k, input int n);
        int ac; logic [7:0] rd;
        repeat (n) begin
            repeat ($urandom_range(0, 2)) @(posedge clock);
            do_fetch(k, ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255)), ac, rd);
        end
    endtask

    task automatic rnd_data(input int k, input int n);
        int ac, lt; logic [7:0] rd;
        repeat (n) begin
            repeat ($urandom_range(0, 2)) @(posedge clock);
            do_data(k, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), ac, lt, rd);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    int ac, ac2, ac3, lt, ica, dca;
    logic [7:0] rd, ird;

    initial begin
        for (int k = 0; k < NI; k++) begin
            i_req[k] = 0; i_addr[k] = 0; d_req[k] = 0; d_we[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
        end
        reset = 1'b1;
        @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            chk("rst_i_ack", k, 32'(i_ack[k]), 0);
            chk("rst_d_ack", k, 32'(d_ack[k]), 0);
            chk("rst_i_rdata", k, 32'(i_rdata[k]), 0);
            chk("rst_d_rdata", k, 32'(d_rdata[k]), 0);
            chk("rst_io_out", k, 32'(io_out[k]), 0);
            chk("rst_busy", k, 32'(busy[k]), 0);
        end
        chk_on = 1'b1;
        @(posedge clock); #1; reset = 1'b0;

        // Write then read back; ack comes ws+2 negedges after req is raised.
        for (int k = 0; k < NI; k++) begin
            do_data(k, 1'b1, 8'h10, 8'h5A, ac, lt, rd);
            chk("wr_latency", k, 32'(lt), (k == 0) ? 3 : 2);
            wr(k, 8'h20, 8'h11);
            do_data(k, 1'b0, 8'h10, 8'h00, ac, lt, rd);
            chk("rd_latency", k, 32'(lt), (k == 0) ? 3 : 2);
            chk("rd_10", k, 32'(rd), 32'h5A);
        end

        // Tie right after reset: data wins, then the pending fetch is served.
        @(posedge clock); #1; reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            fork
                do_fetch(k, 8'h10, ica, ird);
                do_data(k, 1'b0, 8'h20, 8'h00, dca, lt, rd);
            join
            chk("tie1_data_first", k, 32'(dca < ica), 1);
            chk("tie1_i_rdata", k, 32'(ird), 32'h5A);
            chk("tie1_d_rdata", k, 32'(rd), 32'h11);
            // Instruction was granted last, so the next tie goes to data again.
            fork
                do_fetch(k, 8'h20, ica, ird);
                do_data(k, 1'b0, 8'h10, 8'h00, dca, lt, rd);
            join
            chk("tie2_data_first", k, 32'(dca < ica), 1);
            chk("tie2_i_rdata", k, 32'(ird), 32'h11);
        end

        // IO register write and read from both ports.
        for (int k = 0; k < NI; k++) begin
            wr(k, 8'hFF, 8'h3C);
            @(negedge clock);
            chk("io_write", k, 32'(io_out[k]), 32'h3C);
            do_fetch(k, 8'hFF, ac, rd);
            chk("io_fetch", k, 32'(rd), 32'h3C);
            do_data(k, 1'b0, 8'hFF, 8'h00, ac, lt, rd);
            chk("io_dread", k, 32'(rd), 32'h3C);
        end

        // Reset during WAIT drops the write (instance 0 has a WAIT cycle).
        wr(0, 8'h30, 8'h21);
        @(posedge clock); #1;
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'h30; d_wdata[0] = 8'h77;
        @(posedge clock); #1;          // accepted; now in WAIT
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busy", 0, 32'(busy[0]), 0);
        chk("abort_d_ack", 0, 32'(d_ack[0]), 0);
        @(posedge clock); #1;
        d_req[0] = 1'b0; reset = 1'b0;
        repeat (3) @(posedge clock);
        do_data(0, 1'b0, 8'h30, 8'h00, ac, lt, rd);
        chk("abort_mem_kept", 0, 32'(rd), 32'h21);

        // Zero wait states: back-to-back reads every 3 cycles.
        do_data(1, 1'b0, 8'h10, 8'h00, ac, lt, rd);
        chk("b2b_rd0", 1, 32'(rd), 32'h5A);
        do_data(1, 1'b0, 8'h20, 8'h00, ac2, lt, rd);
        chk("b2b_rd1", 1, 32'(rd), 32'h11);
        chk("b2b_gap1", 1, 32'(ac2 - ac), 3);
        do_data(1, 1'b0, 8'h10, 8'h00, ac3, lt, rd);
        chk("b2b_rd2", 1, 32'(rd), 32'h5A);
        chk("b2b_gap2", 1, 32'(ac3 - ac2), 3);

        // Randomised traffic on both ports of both instances.
        fork
            prefill(0);
            prefill(1);
        join
        fork
            rnd_fetch(0, 150);
            rnd_data(0, 150);
            rnd_fetch(1, 150);
            rnd_data(1, 150);
        join
        repeat (4) @(posedge clock);

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test want end before 1ms");
        $fatal(1, "watchdog");
    end

endmodule
